// File: rtl/div_8by4_seq.sv
// Sequential 8-bit by 4-bit unsigned restoring divider.
// Takes a fixed 9 cycles from the accepting edge to the result, whatever the operand values.
module div_8by4_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       done,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;

    // work starts as the dividend; its MSB shifts out each step and the
    // quotient bit shifts in at the LSB, so it holds the quotient after 8 steps.
    logic [7:0] work;
    logic [3:0] dvs;
    logic [4:0] prem;
    logic [3:0] cnt;

    logic       accept;
    logic       last_step;
    logic [4:0] trial;
    logic       fits;

    assign accept    = start && (state != BUSY);
    assign last_step = (state == BUSY) && (cnt == 4'd8);
    assign trial     = (prem << 1) | {4'b0000, work[7]};
    assign fits      = trial >= {1'b0, dvs};
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state always uses <= so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (cnt == 4'd8) state_nxt = DONE;
            DONE:    if (start) state_nxt = BUSY;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work        <= '0;
            dvs         <= '0;
            prem        <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            work <= dividend;
            dvs  <= divisor;
            prem <= '0;
            cnt  <= '0;
        end else if (last_step) begin
            // A zero divisor leaves a partial remainder of garbage; report the fixed code instead.
            quotient    <= (dvs == 4'd0) ? 8'hFF : work;
            remainder   <= (dvs == 4'd0) ? 4'h0 : prem[3:0];
            div_by_zero <= (dvs == 4'd0);
        end else if (state == BUSY) begin
            prem <= fits ? (trial - {1'b0, dvs}) : trial;
            work <= {work[6:0], fits};
            cnt  <= cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_div_8by4_seq.sv
// Self-checking bench for div_8by4_seq: directed corner cases plus 100 random
// operand pairs compared against plain integer division.
module tb_div_8by4_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       done;
    logic       div_by_zero;

    int passed = 0;
    int total  = 0;

    div_8by4_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance past the next rising edge; outputs are sampled and inputs driven 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for done; returns the number of edges taken (20 means it never arrived).
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic check_result(input string tag, input int a, input int b);
        int exp_q, exp_r, exp_z;
        exp_q = (b == 0) ? 255 : a / b;
        exp_r = (b == 0) ? 0 : a % b;
        exp_z = (b == 0) ? 1 : 0;
        check({tag, "_q"}, int'(quotient), exp_q);
        check({tag, "_r"}, int'(remainder), exp_r);
        check({tag, "_dbz"}, int'(div_by_zero), exp_z);
    endtask

    // Pulse start for one cycle, then check latency and result.
    task automatic run_op(input string tag, input int a, input int b);
        int n;
        dividend = 8'(a);
        divisor  = 4'(b);
        start    = 1'b1;
        step();
        check({tag, "_done_low_at_accept"}, int'(done), 0);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        wait_done(n);
        check({tag, "_latency"}, n, 9);
        check_result(tag, a, b);
    endtask

    initial begin
        int n;
        int a, b;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        check("reset_done", int'(done), 0);
        check("reset_q", int'(quotient), 0);
        check("reset_r", int'(remainder), 0);
        check("reset_dbz", int'(div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start raised before the first edge after release must be accepted there.
        run_op("d100_7", 100, 7);

        // Results stay put in DONE while start is low.
        repeat (5) step();
        check("hold_done", int'(done), 1);
        check("hold_q", int'(quotient), 14);
        check("hold_r", int'(remainder), 2);

        run_op("d255_1", 255, 1);
        run_op("d225_15", 225, 15);
        run_op("d0_5", 0, 5);
        run_op("d14_15", 14, 15);
        run_op("d200_0", 200, 0);
        run_op("d9_3", 9, 3);

        // A start pulse with new operands mid-BUSY is ignored.
        dividend = 8'd100;
        divisor  = 4'd7;
        start    = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        dividend = 8'd50;
        divisor  = 4'd5;
        start    = 1'b1;
        step();
        check("ign_done_low", int'(done), 0);
        start = 1'b0;
        wait_done(n);
        check("ign_latency", n, 5);
        check_result("ign", 100, 7);

        // Held start gives back-to-back operations with one done cycle between.
        dividend = 8'd20;
        divisor  = 4'd3;
        start    = 1'b1;
        step();
        dividend = 8'd30;
        divisor  = 4'd4;
        wait_done(n);
        check("b2b_lat1", n, 9);
        check_result("b2b1", 20, 3);
        step();
        check("b2b_done_one_cycle", int'(done), 0);
        dividend = 8'd0;
        divisor  = 4'd1;
        wait_done(n);
        check("b2b_lat2", n, 9);
        check_result("b2b2", 30, 4);
        start = 1'b0;
        step();

        // Reset mid-operation clears outputs at once and aborts the division.
        dividend = 8'd100;
        divisor  = 4'd7;
        start    = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check("midrst_done", int'(done), 0);
        check("midrst_q", int'(quotient), 0);
        check("midrst_r", int'(remainder), 0);
        check("midrst_dbz", int'(div_by_zero), 0);
        repeat (2) step();
        check("midrst_no_result", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("d81_9", 81, 9);

        // Randomized operands, including occasional zero divisors.
        for (int i = 0; i < 100; i++) begin
            a = int'($urandom_range(0, 255));
            b = (i % 10 == 0) ? 0 : int'($urandom_range(0, 15));
            run_op("rand", a, b);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
